// File: rtl/reg_bank_onehot_wr.sv
// Integer register file driven by a one-hot write select from the address decoder.
// One synchronous write port, two combinational read ports, x0 hardwired to zero.
module reg_bank_onehot_wr #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [NREGS-1:0]         wr_sel,
  input  logic [WIDTH-1:0]         wd,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  output logic [WIDTH-1:0]         rd1,
  output logic [WIDTH-1:0]         rd2,
  output logic                     sel_err
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             selErr_q;
  logic             selErr_d;
  logic [NREGS-1:0] selMinusOne;
  logic             selValid;
  logic             doWrite;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign selMinusOne = wr_sel - NREGS'(1);
  assign selValid    = (wr_sel != '0) && ((wr_sel & selMinusOne) == '0);
  assign doWrite     = we && !rst && selValid;

  always_comb begin
    regs_d   = regs_q;
    selErr_d = selErr_q | (we & ~selValid);
    for (int k = 1; k < NREGS; k++) begin
      if (doWrite && wr_sel[k]) begin
        regs_d[k] = wd;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_q[k] <= '0;
      end
      selErr_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      selErr_q <= selErr_d;
    end
  end

  // Forwarding is keyed on the select bit itself, so rs1 == rs2 always agree.
  always_comb begin
    rd1 = regs_q[rs1];
    if (rs1 == '0) begin
      rd1 = '0;
    end else if ((BYPASS != 0) && doWrite && wr_sel[rs1]) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs_q[rs2];
    if (rs2 == '0) begin
      rd2 = '0;
    end else if ((BYPASS != 0) && doWrite && wr_sel[rs2]) begin
      rd2 = wd;
    end
  end

  assign sel_err = selErr_q;

endmodule

// File: doc/reg_bank_onehot_wr.md
Name: reg_bank_onehot_wr

Overview:
- 32-entry integer register file core that consumes the one-hot write-select vector produced by the write-address decoder.
- Provides one synchronous write port and two combinational read ports.
- Register 0 is hardwired to zero.
- Includes optional write-to-read bypass and a sticky error flag for malformed (non-one-hot) write selects.

Parameters:
- WIDTH, 32, data width of each register in bits.
- NREGS, 32, number of registers; width of the one-hot select (power of two).
- BYPASS, 1, 1 = a read of the register being written this cycle returns the write data; 0 = returns the old contents.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable for this cycle.
- wr_sel  input  NREGS  one-hot write-register select from the decoder.
- wd  input  WIDTH  write data.
- rs1  input  $clog2(NREGS)  read port 1 register index.
- rs2  input  $clog2(NREGS)  read port 2 register index.
- rd1  output  WIDTH  read port 1 data.
- rd2  output  WIDTH  read port 2 data.
- sel_err  output  1  sticky flag: a write was attempted with an invalid select.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst is sampled only on the rising clk edge.
- Reset:
  - Rising edge with rst=1: all NREGS registers <= 0, sel_err <= 0.
  - rst dominates we; no write occurs in a reset cycle.
  - After reset: rd1 = rd2 = 0 for any index.
- Select validity (combinational): valid when wr_sel has exactly one bit set. Popcount 0 or >=2 is invalid.
- Write, on rising edge with rst=0, we=1:
  - Valid select, bit k, k!=0: reg[k] <= wd. All other registers hold.
  - Valid select, k=0: no write, no error (write to x0 is legal and discarded).
  - Invalid select: no register changes; sel_err <= 1.
- we=0: no register changes, sel_err holds; wr_sel contents ignored (no error).
- sel_err is sticky: once 1, stays 1 until rst.
- Read, combinational, zero-cycle latency:
  - rdN = 0 when rsN = 0, regardless of writes or bypass.
  - BYPASS=1 and (we=1, rst=0, valid select, select bit rsN set, rsN!=0): rdN = wd in the same cycle.
  - Otherwise rdN = reg[rsN], i.e. the value written on the previous edge.
  - Bypass never forwards on an invalid select or during rst.
- rs1 = rs2: both ports return identical data, including the bypass case.
- Write latency: data written on edge t is visible via the non-bypass path after edge t, and via bypass during cycle t when BYPASS=1.
- No other state exists; no handshakes; one write per cycle maximum.

Test Plan:
- Reset, then read all indices 0..31 on both ports -> rd1 = rd2 = 0, sel_err = 0.
- we=1, wr_sel=32'h0000_0020, wd=32'hDEAD_BEEF, then next cycle rs1=5, rs2=5 -> rd1 = rd2 = 32'hDEAD_BEEF. Registers 1..4 and 6..31 remain 0.
- we=1, wr_sel=32'h0000_0001, wd=32'h1234_5678, rs1=0 -> rd1 = 0 during and after the edge; sel_err = 0.
- BYPASS=1: we=1, wr_sel=32'h8000_0000, wd=32'hA5A5_A5A5, rs2=31 in the same cycle -> rd2 = 32'hA5A5_A5A5 before the edge. With BYPASS=0 -> rd2 = prior value (0), then 32'hA5A5_A5A5 after the edge.
- we=1, wr_sel=32'h0000_0006, wd=32'hFFFF_FFFF -> reg1 and reg2 unchanged, sel_err = 1. Then a valid write to reg3 -> reg3 written, sel_err stays 1 until rst=1, which clears sel_err and all registers.
- rst=1 and we=1, wr_sel=32'h0000_0100, wd=32'h55 in the same cycle -> reg8 = 0 after the edge; bypass on rs1=8 gives rd1 = 0 during that cycle.
